// File: rtl/alu_seq_pkg.sv
// Shared opcode and state types for the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_GT   = 4'd14,
        OP_EQ   = 4'd15
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic is_multicycle(op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative one-bit-per-cycle multiplier (shift-add) and restoring divider sharing
// one register set. lo/hi present the post-iteration values so the final step and the
// result capture happen on the same edge.
module alu_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rs;
    logic             div_ge;

    assign done = active_q && (cnt_q == CW'(WIDTH - 1));
    assign lo   = lo_d;
    assign hi   = hi_d;

    // MUL: hi accumulates, lo holds the multiplier and collects product bits.
    // DIV: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_rs   = {hi_q, lo_q[WIDTH-1]};
        div_ge   = div_rs >= {1'b0, opnd_q};
        cnt_d    = cnt_q;
        active_d = active_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            is_div_d = is_div;
            hi_d     = '0;
            lo_d     = is_div ? a : b;
            opnd_d   = is_div ? b : a;
        end else if (active_q) begin
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                active_d = 1'b0;
            end
            if (is_div_q) begin
                hi_d = div_ge ? (div_rs[WIDTH-1:0] - opnd_q) : div_rs[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], div_ge};
            end else begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, registered results and status flags.
// Single-cycle ops load on the accept edge; MUL/DIV iterate in alu_muldiv_iter.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             div_err
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             div_err_q, div_err_d;

    op_e              op_in;
    logic             accept, xfer, start, div_by_zero;
    logic             md_done;
    logic [WIDTH-1:0] md_lo, md_hi;

    logic [SHW-1:0]   amt, amt_n;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] b_neg, sub_res;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_c, sc_ov, sc_err;

    assign op_in       = op_e'(op);
    assign in_ready    = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign xfer        = out_valid_q && out_ready;
    assign div_by_zero = (op_in == OP_DIV) && (b == '0);
    assign start       = accept && is_multicycle(op_in) && !div_by_zero;

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .is_div(op_in == OP_DIV),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .lo    (md_lo),
        .hi    (md_hi)
    );

    // amt_n == WIDTH-amt mod WIDTH, so a rotate by 0 ORs a with itself.
    always_comb begin
        amt     = b[SHW-1:0];
        amt_n   = -amt;
        add_sum = {1'b0, a} + {1'b0, b};
        b_neg   = ~b + 1'b1;
        sub_res = a + b_neg;
        sc_res  = '0;
        sc_hi   = '0;
        sc_c    = 1'b0;
        sc_ov   = 1'b0;
        sc_err  = 1'b0;
        unique case (op_in)
            OP_ADD: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_c   = add_sum[WIDTH];
                sc_ov  = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sc_res = sub_res;
                sc_c   = a < b;
                sc_ov  = (a[MSB] == b_neg[MSB]) && (sub_res[MSB] != a[MSB]);
            end
            OP_DIV: begin
                sc_res = '1;
                sc_hi  = a;
                sc_err = 1'b1;
            end
            OP_SHL:  sc_res = a << amt;
            OP_SHR:  sc_res = a >> amt;
            OP_ROL:  sc_res = (a << amt) | (a >> amt_n);
            OP_ROR:  sc_res = (a >> amt) | (a << amt_n);
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_NAND: sc_res = ~(a & b);
            OP_XNOR: sc_res = ~(a ^ b);
            OP_GT:   sc_res = {{(WIDTH - 1){1'b0}}, a > b};
            OP_EQ:   sc_res = {{(WIDTH - 1){1'b0}}, a == b};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        div_err_d   = div_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (start) begin
                        state_d = ST_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = sc_res;
                        result_hi_d = sc_hi;
                        carry_d     = sc_c;
                        overflow_d  = sc_ov;
                        zero_d      = (sc_res == '0);
                        div_err_d   = sc_err;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = md_lo;
                    result_hi_d = md_hi;
                    carry_d     = 1'b0;
                    overflow_d  = 1'b0;
                    zero_d      = (md_lo == '0);
                    div_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            div_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            div_err_q   <= div_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign div_err   = div_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vector table, handshake corner
// sequences and a randomized scoreboard against an arithmetic reference model.
module tb_alu_seq;

    localparam int NRAND = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] op = '0;
    logic       in_ready, out_valid, carry, overflow, zero, div_err;
    logic [7:0] result, result_hi;

    alu_seq #(
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .result_hi(result_hi),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .div_err  (div_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Packed as {result, result_hi, carry, overflow, zero, div_err}.
    function automatic int ov_rule(input int x, input int y, input int r);
        return ((x >= 128) == (y >= 128)) && ((r >= 128) != (x >= 128));
    endfunction

    function automatic logic [19:0] model(input int o, input int x, input int y);
        int r = 0, h = 0, c = 0, v = 0, e = 0, s, amt;
        amt = y % 8;
        case (o)
            0: begin s = x + y; r = s % 256; c = (s > 255); v = ov_rule(x, y, r); end
            1: begin r = (x - y + 256) % 256; c = (x < y); v = ov_rule(x, (256 - y) % 256, r); end
            2: begin s = x * y; r = s % 256; h = s / 256; end
            3: if (y == 0) begin r = 255; h = x; e = 1; end else begin r = x / y; h = x % y; end
            4: r = (x << amt) % 256;
            5: r = x >> amt;
            6: r = ((x << amt) | (x >> (8 - amt))) % 256;
            7: r = ((x >> amt) | (x << (8 - amt))) % 256;
            8: r = x & y;
            9: r = x | y;
            10: r = x ^ y;
            11: r = 255 - (x | y);
            12: r = 255 - (x & y);
            13: r = 255 - (x ^ y);
            14: r = (x > y) ? 1 : 0;
            default: r = (x == y) ? 1 : 0;
        endcase
        return {8'(r), 8'(h), 1'(c), 1'(v), (r == 0), 1'(e)};
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [19:0] exp;
        int          lat;
    } vec_t;

    function automatic vec_t mk(input int o, input int x, input int y, input int r,
                                input int h, input bit c, input bit v, input bit z,
                                input bit e, input int lat);
        vec_t t;
        t.op  = 4'(o);
        t.a   = 8'(x);
        t.b   = 8'(y);
        t.exp = {8'(r), 8'(h), c, v, z, e};
        t.lat = lat;
        return t;
    endfunction

    // Scoreboard monitor: samples at negedge, inputs only change just after posedge.
    logic [19:0] exp_q[$];
    bit sb_en = 1'b0;
    bit will_accept = 1'b0;
    int n_acc = 0;
    int n_xfer = 0;

    initial begin
        forever begin
            @(negedge clk);
            will_accept = in_valid && in_ready;
            if (sb_en && !rst) begin
                if (will_accept) begin
                    exp_q.push_back(model(int'(op), int'(a), int'(b)));
                    n_acc++;
                end
                if (out_valid && out_ready) begin
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_spurious: got result 0x%0h with no op outstanding",
                                 result);
                    end else begin
                        check("sb_result", {result, result_hi, carry, overflow, zero, div_err},
                              exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_op(input vec_t v, output logic [19:0] got, output int lat);
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = v.op;
        a         = v.a;
        b         = v.b;
        @(negedge clk);
        check("in_ready_before_op", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = {result, result_hi, carry, overflow, zero, div_err};
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic [19:0] got;
        int          lat, n, issued;

        // Opcode sweep with a=5, b=2, then flag and boundary vectors.
        tbl.push_back(mk(0, 5, 2, 7, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 5, 2, 3, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(2, 5, 2, 10, 0, 0, 0, 0, 0, 9));
        tbl.push_back(mk(3, 5, 2, 2, 1, 0, 0, 0, 0, 9));
        tbl.push_back(mk(4, 5, 2, 20, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(5, 5, 2, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(6, 5, 2, 20, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(7, 5, 2, 'h41, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(8, 5, 2, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(9, 5, 2, 7, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(10, 5, 2, 7, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(11, 5, 2, 'hF8, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(12, 5, 2, 'hFF, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(13, 5, 2, 'hF8, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(14, 5, 2, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(15, 5, 2, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 'h7F, 'h01, 'h80, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 'h00, 'h01, 'hFF, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 'hFF, 'h01, 'h00, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(2, 'hFF, 'hFF, 'h01, 'hFE, 0, 0, 0, 0, 9));
        tbl.push_back(mk(3, 200, 7, 28, 4, 0, 0, 0, 0, 9));
        tbl.push_back(mk(3, 9, 0, 'hFF, 9, 0, 0, 0, 1, 1));
        tbl.push_back(mk(4, 5, 9, 10, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(7, 'h81, 8, 'h81, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(15, 'hA5, 'hA5, 1, 0, 0, 0, 0, 0, 1));

        // Reset state.
        #1 rst = 1'b1;
        #2;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", {result, result_hi, carry, overflow, zero, div_err}, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            do_op(tbl[i], got, lat);
            check($sformatf("vec%0d_op%0d_out", i, tbl[i].op), got, tbl[i].exp);
            check($sformatf("vec%0d_op%0d_latency", i, tbl[i].op), lat, tbl[i].lat);
        end

        // Backpressure: result must hold and in_ready stay low while stalled.
        @(posedge clk);
        #2;
        sb_en     = 1'b1;
        n_xfer    = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 4'd0;
        a         = 8'd3;
        b         = 8'd4;
        @(posedge clk);
        #2 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_out_valid", i), out_valid, 1);
            check($sformatf("stall%0d_result", i), result, 7);
            check($sformatf("stall%0d_in_ready", i), in_ready, 0);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            op       = 4'd0;
            a        = 8'(i * 16 + 1);
            b        = 8'(i);
            @(negedge clk);
            check($sformatf("b2b%0d_in_ready", i), in_ready, 1);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_transfers", n_xfer, 5);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Reset during MUL iteration.
        sb_en = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        op       = 4'd2;
        a        = 8'd13;
        b        = 8'd11;
        @(posedge clk);
        #2 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midmul_rst_out_valid", out_valid, 0);
        check("midmul_rst_in_ready", in_ready, 0);
        check("midmul_rst_outputs", {result, result_hi, carry, overflow, zero, div_err}, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("midmul_release_in_ready", in_ready, 1);
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("midmul_no_stale_result", n, 0);
        do_op(mk(0, 5, 2, 7, 0, 0, 0, 0, 0, 1), got, lat);
        check("midmul_after_add", got, {8'd7, 8'd0, 4'b0000});
        check("midmul_after_add_latency", lat, 1);

        // Randomized traffic with random in_valid/out_ready against the model.
        @(posedge clk);
        #2;
        exp_q.delete();
        n_acc  = 0;
        n_xfer = 0;
        sb_en  = 1'b1;
        issued = 0;
        for (int cyc = 0; cyc < 40000 && issued < NRAND; cyc++) begin
            if (in_valid && will_accept) begin
                issued++;
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && issued < NRAND && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                op       = 4'($urandom_range(0, 15));
                a        = 8'($urandom);
                b        = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            end
            @(posedge clk);
            #2;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rand_issued", issued, NRAND);
        check("rand_drain", exp_q.size(), 0);
        check("rand_acc_vs_xfer", n_xfer, n_acc);
        sb_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
